// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the slow-FPU scheduler and the slow FPU decoder.
package fpu_sched_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} sched_state_t;

   localparam logic [31:0] NAN_VALUE = 32'h7FC0_0000;

   // Slow-op opcodes, kept in sync with the slow FPU decoder
   localparam logic [4:0] OP_FDIV  = 5'h00;
   localparam logic [4:0] OP_FSQRT = 5'h01;
   localparam logic [4:0] OP_FREM  = 5'h02;

endpackage

// File: rtl/sched_watchdog.sv
// Free-running cycle counter with a terminal-count flag; used for both WAIT and DRAIN.
module sched_watchdog #(
   parameter int CNT_W    = 7,
   parameter int TERMINAL = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   assign tc = (cnt == CNT_W'(TERMINAL));

endmodule

// File: rtl/slow_fpu_sched.sv
// Issues one slow FPU op at a time from E, stalls until it completes, holds the result
// while E is frozen, and drains orphaned ops after a flush.
module slow_fpu_sched
   import fpu_sched_pkg::*;
#(
   parameter int          OP_W           = 5,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter int          CNT_W          = 7,
   parameter logic [31:0] NAN_VALUE      = fpu_sched_pkg::NAN_VALUE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [OP_W-1:0] op,
   input  logic [31:0]     src_a,
   input  logic [31:0]     src_b,
   input  logic            hold_e,
   input  logic            flush_e,
   output logic            fpu_start,
   output logic [OP_W-1:0] fpu_op,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   input  logic            fpu_valid,
   input  logic [31:0]     fpu_result,
   output logic            stall_fpu,
   output logic [31:0]     result,
   output logic            result_valid,
   output logic            timeout_err
);

   sched_state_t state, state_nx;
   logic         issue;
   logic         tc;

   // Counter restarts on every state change, so it is zero on entry to WAIT/DRAIN
   sched_watchdog #(
      .CNT_W    (CNT_W),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (state_nx != state),
      .en  ((state == WAIT) || (state == DRAIN)),
      .tc  (tc)
   );

   always_comb begin
      state_nx  = state;
      issue     = 1'b0;
      stall_fpu = 1'b0;
      case (state)
         IDLE: begin
            if (req && !flush_e) begin
               issue     = 1'b1;
               stall_fpu = 1'b1;
               state_nx  = WAIT;
            end
         end
         WAIT: begin
            stall_fpu = 1'b1;
            if (flush_e)
               state_nx = DRAIN;
            else if (fpu_valid || tc)
               state_nx = DONE;
         end
         DONE: begin
            if (flush_e || !hold_e)
               state_nx = IDLE;
         end
         DRAIN: begin
            // A new op waits here and issues from IDLE once the orphan returns
            stall_fpu = req && !flush_e;
            if (fpu_valid || tc)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         fpu_start   <= 1'b0;
         fpu_op      <= '0;
         fpu_a       <= '0;
         fpu_b       <= '0;
         result      <= '0;
         timeout_err <= 1'b0;
      end else begin
         state     <= state_nx;
         fpu_start <= issue;
         if (issue) begin
            fpu_op <= op;
            fpu_a  <= src_a;
            fpu_b  <= src_b;
         end
         if (state == WAIT && !flush_e) begin
            if (fpu_valid) begin
               result <= fpu_result;
            end else if (tc) begin
               result      <= NAN_VALUE;
               timeout_err <= 1'b1;
            end
         end
         if (state == DRAIN && !fpu_valid && tc)
            timeout_err <= 1'b1;
      end
   end

   assign result_valid = (state == DONE);

endmodule

// File: tb/tb_slow_fpu_sched.sv
// Directed bench for slow_fpu_sched: issue/latency, hold, flush/drain, timeout, async reset.
module tb_slow_fpu_sched;
   import fpu_sched_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req = 1'b0, hold_e = 1'b0, flush_e = 1'b0, fpu_valid = 1'b0;
   logic [4:0]  op = '0;
   logic [31:0] src_a = '0, src_b = '0, fpu_result = '0;
   logic        fpu_start, stall_fpu, result_valid, timeout_err;
   logic [4:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, result;

   int n_cmp = 0, n_err = 0, n_start = 0, s0 = 0;

   slow_fpu_sched dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .src_a(src_a), .src_b(src_b),
      .hold_e(hold_e), .flush_e(flush_e), .fpu_start(fpu_start), .fpu_op(fpu_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_valid(fpu_valid), .fpu_result(fpu_result),
      .stall_fpu(stall_fpu), .result(result), .result_valid(result_valid),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (fpu_start) n_start++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs just after the edge, then sample on the falling edge
   task automatic step(input logic r, input logic h, input logic f, input logic v);
      @(posedge clk); #1;
      req = r; hold_e = h; flush_e = f; fpu_valid = v;
      @(negedge clk);
   endtask

   initial begin
      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst start", fpu_start, 0);
      chk("rst stall", stall_fpu, 0);
      chk("rst rv", result_valid, 0);
      chk("rst result", result, 0);
      chk("rst terr", timeout_err, 0);
      chk("rst fpu_a", fpu_a, 0);
      @(posedge clk); #1 rst = 1'b0;

      // basic op, valid four cycles after start
      op = OP_FDIV; src_a = 32'h3F80_0000; src_b = 32'h4000_0000; s0 = n_start;
      step(1, 0, 0, 0);
      chk("t1 stall t", stall_fpu, 1);
      chk("t1 start t", fpu_start, 0);
      step(1, 0, 0, 0);
      chk("t1 start t+1", fpu_start, 1);
      chk("t1 fpu_a", fpu_a, 32'h3F80_0000);
      chk("t1 fpu_b", fpu_b, 32'h4000_0000);
      chk("t1 fpu_op", fpu_op, OP_FDIV);
      chk("t1 stall t+1", stall_fpu, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         chk("t1 start wait", fpu_start, 0);
         chk("t1 stall wait", stall_fpu, 1);
      end
      fpu_result = 32'h3F00_0000;
      step(1, 0, 0, 1);
      chk("t1 stall t+5", stall_fpu, 1);
      chk("t1 rv t+5", result_valid, 0);
      step(1, 0, 0, 0);
      chk("t1 rv t+6", result_valid, 1);
      chk("t1 result", result, 32'h3F00_0000);
      chk("t1 stall t+6", stall_fpu, 0);
      step(0, 0, 0, 0);
      chk("t1 rv t+7", result_valid, 0);
      chk("t1 issues", n_start - s0, 1);

      // minimum latency then hold in DONE
      src_a = 32'h4040_0000; src_b = 32'h3F80_0000; s0 = n_start;
      fpu_result = 32'h4040_0000;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("t2 start", fpu_start, 1);
      step(1, 0, 0, 1);
      chk("t2 stall t+2", stall_fpu, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0);
         chk("t2 rv hold", result_valid, 1);
         chk("t2 result hold", result, 32'h4040_0000);
         chk("t2 stall hold", stall_fpu, 0);
         chk("t2 start hold", fpu_start, 0);
      end
      step(1, 0, 0, 0);
      chk("t2 rv release", result_valid, 1);
      step(0, 0, 0, 0);
      chk("t2 rv idle", result_valid, 0);
      chk("t2 start idle", fpu_start, 0);
      chk("t2 issues", n_start - s0, 1);

      // flush in WAIT, orphan result discarded
      src_a = 32'h1111_1111;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("t3 stall flush", stall_fpu, 1);
      step(0, 0, 0, 0);
      chk("t3 stall drain", stall_fpu, 0);
      chk("t3 rv drain", result_valid, 0);
      fpu_result = 32'hDEAD_BEEF;
      step(0, 0, 0, 1);
      chk("t3 rv orphan", result_valid, 0);
      step(0, 0, 0, 0);
      chk("t3 rv after", result_valid, 0);
      chk("t3 result kept", result, 32'h4040_0000);

      // new req arrives during DRAIN
      src_a = 32'hAAAA_0001; src_b = 32'hAAAA_0002; s0 = n_start;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      src_a = 32'hBBBB_0001; src_b = 32'hBBBB_0002;
      step(1, 0, 0, 0);
      chk("t4 stall drain", stall_fpu, 1);
      chk("t4 start drain", fpu_start, 0);
      chk("t4 fpu_a stable", fpu_a, 32'hAAAA_0001);
      step(1, 0, 0, 0);
      chk("t4 stall drain2", stall_fpu, 1);
      step(1, 0, 0, 1);
      chk("t4 stall orphan", stall_fpu, 1);
      step(1, 0, 0, 0);
      chk("t4 stall idle", stall_fpu, 1);
      chk("t4 start idle", fpu_start, 0);
      step(1, 0, 0, 0);
      chk("t4 start new", fpu_start, 1);
      chk("t4 fpu_a new", fpu_a, 32'hBBBB_0001);
      chk("t4 fpu_b new", fpu_b, 32'hBBBB_0002);
      fpu_result = 32'h3FC0_0000;
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      chk("t4 rv", result_valid, 1);
      chk("t4 result", result, 32'h3FC0_0000);
      step(0, 0, 0, 0);
      chk("t4 issues", n_start - s0, 2);

      // watchdog timeout: 64 WAIT cycles with no valid
      op = OP_FREM;
      step(1, 0, 0, 0);
      chk("t5 terr start", timeout_err, 0);
      step(1, 0, 0, 0);
      chk("t5 start", fpu_start, 1);
      for (int i = 2; i <= 63; i++) step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("t5 stall last", stall_fpu, 1);
      chk("t5 rv last", result_valid, 0);
      chk("t5 terr last", timeout_err, 0);
      step(1, 0, 0, 0);
      chk("t5 rv", result_valid, 1);
      chk("t5 result nan", result, 32'h7FC0_0000);
      chk("t5 terr", timeout_err, 1);
      chk("t5 stall", stall_fpu, 0);
      step(0, 0, 0, 0);
      chk("t5 rv idle", result_valid, 0);
      chk("t5 terr sticky", timeout_err, 1);

      // async reset while in WAIT, then a clean reissue
      op = OP_FSQRT; src_a = 32'h4080_0000; src_b = 32'h0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      #2 rst = 1'b1; req = 1'b0;
      #1;
      chk("t6 rst start", fpu_start, 0);
      chk("t6 rst stall", stall_fpu, 0);
      chk("t6 rst rv", result_valid, 0);
      chk("t6 rst result", result, 0);
      chk("t6 rst terr", timeout_err, 0);
      chk("t6 rst fpu_a", fpu_a, 0);
      chk("t6 rst fpu_op", fpu_op, 0);
      @(posedge clk); #1 rst = 1'b0;
      step(1, 0, 0, 0);
      chk("t6 stall reissue", stall_fpu, 1);
      step(1, 0, 0, 0);
      chk("t6 start reissue", fpu_start, 1);
      chk("t6 fpu_a reissue", fpu_a, 32'h4080_0000);
      chk("t6 fpu_op reissue", fpu_op, OP_FSQRT);
      fpu_result = 32'h4000_0000;
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      chk("t6 rv", result_valid, 1);
      chk("t6 result", result, 32'h4000_0000);
      step(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/slow_fpu_sched.md
Name: slow_fpu_sched

Overview:
Sequences the multi-cycle (slow) FPU unit on behalf of the execute stage. It latches operands when a slow FPU op reaches E, pulses a start to the slow FPU, and stalls the pipeline until the FPU reports valid. It then holds the result for E while the pipeline is frozen for other reasons, and drains in-flight ops on flush. It sits between exec, the hazard unit and the slow FPU; fast FPU ops bypass it.

Parameters:
OP_W, 5, width of slow FPU opcode
TIMEOUT_CYCLES, 64, WAIT cycles before abort; must be ≥2
CNT_W, 7, watchdog counter width; must hold TIMEOUT_CYCLES
NAN_VALUE, 32'h7FC0_0000, result substituted on timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  1  slow FPU op present in E (valid & !fast_fpu_dispatch)
op  in  OP_W  slow FPU opcode
src_a  in  32  forwarded fpu_rd1
src_b  in  32  forwarded fpu_rd2
hold_e  in  1  E held by another hazard-unit stall
flush_e  in  1  E flushed this cycle
fpu_start  out  1  one-cycle issue pulse to slow FPU
fpu_op  out  OP_W  latched opcode
fpu_a  out  32  latched operand a
fpu_b  out  32  latched operand b
fpu_valid  in  1  slow FPU result valid (single-cycle pulse)
fpu_result  in  32  slow FPU result
stall_fpu  out  1  to hazard unit: freeze F/D/E
result  out  32  result for exec → data_exec fpu_result
result_valid  out  1  result is valid for the op in E
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async): state=IDLE. fpu_start, fpu_op, fpu_a, fpu_b, result, result_valid, timeout_err and the counter are all 0. Reset mid-operation discards everything; the slow FPU shares rst.
- States: IDLE, WAIT, DONE, DRAIN.
- IDLE: if req & !flush_e, register op/src_a/src_b, assert fpu_start on the next cycle (registered, exactly 1 cycle), and go to WAIT. fpu_valid in IDLE is ignored.
- stall_fpu is combinational: high in (IDLE & req & !flush_e), in WAIT, and in (DRAIN & req & !flush_e). A new op is therefore frozen in E from its first cycle.
- WAIT: the counter increments each cycle.
  - fpu_valid: capture fpu_result into result, set result_valid, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid: set result=NAN_VALUE, result_valid=1, timeout_err=1, go to DONE.
  - flush_e (takes priority over fpu_valid): go to DRAIN, result_valid=0.
- DONE: result_valid=1 and stall_fpu=0.
  - Stay while hold_e=1. The held req must not reissue.
  - Go to IDLE and clear result_valid when hold_e=0 (the instruction leaves E) or flush_e=1.
- DRAIN: wait for the orphaned fpu_valid and discard its result.
  - On fpu_valid or timeout: go to IDLE, counter=0; timeout also sets timeout_err.
  - A req arriving during DRAIN stalls and issues from IDLE next cycle. No two ops are ever outstanding.
- Minimum latency: req at cycle t, fpu_start at t+1, earliest valid at t+2, result_valid at t+3, stall released at t+3.
- fpu_a/fpu_b/fpu_op remain stable from issue until leaving WAIT/DRAIN.
- Counter resets to 0 on entering WAIT or DRAIN.
- timeout_err is cleared only by rst.

Decomposition:
- Shared package fpu_sched_pkg holds:
  - enum sched_state_t {IDLE, WAIT, DONE, DRAIN}
  - localparam NAN_VALUE
  - the slow-op opcode constants shared with the slow FPU decoder
- Sub-module sched_watchdog (counter + terminal compare, clear/enable inputs) is natural; reuse it for the DRAIN timeout.

Test Plan:
- Basic op: req=1 with src_a=3F800000, src_b=40000000. FPU returns valid with 3F000000 four cycles after start. Expect fpu_start single pulse at t+1, stall_fpu high t..t+5, result=3F000000 with result_valid at t+6, one issue only.
- Hold in DONE: as above with hold_e=1 for 3 cycles after completion. Expect result_valid held and no second fpu_start; IDLE after hold_e drops.
- Flush in WAIT: flush_e at t+2, fpu_valid at t+4 with DEADBEEF. Expect DRAIN, stall_fpu=0, result_valid never 1, result not updated.
- Req during DRAIN: new req at t+3 while DRAIN. Expect stall until drain valid, then fpu_start with the new operands.
- Timeout: no fpu_valid for 64 cycles. Expect result=7FC00000, result_valid=1, timeout_err=1 (sticky).
- Async reset in WAIT: assert rst between clock edges. Expect all outputs 0 immediately; after release, req reissues normally.
